// File: rtl/axi_mem_slave.sv
// axi_mem_slave
// Single-beat AXI4 memory target. Terminates the AW, W, B, AR and R channels
// in front of a word-addressed RAM. Write address and write data may arrive
// in either order or together. Read data is returned a fixed number of cycles
// after the read address is accepted. The read and write engines are
// independent and may run concurrently.
module axi_mem_slave #(
    parameter int ADDRWIDTH    = 32,
    parameter int DATAWIDTH    = 32,   // 32 or 64
    parameter int MEMDEPTHLOG2 = 10,
    parameter int RDLATENCY    = 2     // 1..15
) (
    input  logic                 clk,
    input  logic                 nreset,

    input  logic [ADDRWIDTH-1:0] awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [2:0]           awprot,

    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic                 wlast,

    output logic                 bvalid,
    input  logic                 bready,

    input  logic [ADDRWIDTH-1:0] araddr,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [2:0]           arprot,

    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready
);

    // Byte-lane bits dropped from the byte address to form the word index.
    localparam int A     = (DATAWIDTH == 64) ? 3 : 2;
    localparam int IW    = MEMDEPTHLOG2;
    localparam int DEPTH = 1 << MEMDEPTHLOG2;

    // Value loaded into the latency counter on read-address acceptance.
    localparam logic [3:0] RDLAT_LOAD = 4'(RDLATENCY - 1);

    // Write FSM states.
    localparam logic [1:0] WIDLE = 2'd0;  // nothing held
    localparam logic [1:0] WADDR = 2'd1;  // address held, waiting for data
    localparam logic [1:0] WDATA = 2'd2;  // data held, waiting for address
    localparam logic [1:0] WRESP = 2'd3;  // write committed, presenting bvalid

    // Read FSM states.
    localparam logic [1:0] RIDLE = 2'd0;  // ready for a read address
    localparam logic [1:0] RWAIT = 2'd1;  // counting down the read latency
    localparam logic [1:0] RDATA = 2'd2;  // presenting rvalid/rdata

    logic [1:0]           wstate;
    logic [IW-1:0]        waddr_q;   // address held in WADDR
    logic [DATAWIDTH-1:0] wdata_q;   // data held in WDATA

    logic [1:0]           rstate;
    logic [IW-1:0]        raddr_q;   // word index of the outstanding read
    logic [3:0]           rcnt;      // remaining wait cycles in RWAIT

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;

    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic [DATAWIDTH-1:0] wr_data;

    // Word-addressed storage; power-up content is all zeros.
    logic [DATAWIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Protection and last-beat qualifiers carry no meaning for this target,
    // and address bits outside the word index are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, wlast, awaddr, araddr};

    // Extract the RAM word index from a byte address (upper bits alias).
    function automatic logic [IW-1:0] word_idx(input logic [ADDRWIDTH-1:0] addr);
        return addr[IW+A-1:A];
    endfunction

    // Readies depend on FSM state only, never on any incoming valid.
    assign awready = (wstate == WIDLE) || (wstate == WDATA);
    assign wready  = (wstate == WIDLE) || (wstate == WADDR);
    assign arready = (rstate == RIDLE);

    // Responses are decoded straight from the registered FSM state.
    assign bvalid  = (wstate == WRESP);
    assign rvalid  = (rstate == RDATA);

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid  & wready;
    assign ar_hs = arvalid & arready;

    // Select address/data for the handshake that completes a write.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        wr_en   = 1'b0;
        wr_idx  = word_idx(awaddr);
        wr_data = wdata;
        case (wstate)
            WIDLE: wr_en = aw_hs & w_hs;
            WADDR: begin
                wr_en  = w_hs;
                wr_idx = waddr_q;
            end
            WDATA: begin
                wr_en   = aw_hs;
                wr_data = wdata_q;
            end
            default: wr_en = 1'b0;
        endcase
    end

    // Write channel sequencing: hold whichever half arrives first.
    always_ff @(posedge clk or negedge nreset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!nreset) begin
            wstate  <= WIDLE;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (wstate)
                WIDLE: begin
                    if (aw_hs && w_hs) begin
                        wstate <= WRESP;
                    end else if (aw_hs) begin
                        waddr_q <= word_idx(awaddr);
                        wstate  <= WADDR;
                    end else if (w_hs) begin
                        wdata_q <= wdata;
                        wstate  <= WDATA;
                    end
                end
                WADDR: if (w_hs)   wstate <= WRESP;
                WDATA: if (aw_hs)  wstate <= WRESP;
                WRESP: if (bready) wstate <= WIDLE;
                default:           wstate <= WIDLE;
            endcase
        end
    end

    // RAM write port; the word is written on the completing handshake edge.
    // A read capturing the same word on this edge still sees the old word.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left out of reset; content survives nreset.
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read channel sequencing: count the latency, then capture and hold rdata.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rstate  <= RIDLE;
            raddr_q <= '0;
            rcnt    <= '0;
            rdata   <= '0;
        end else begin
            case (rstate)
                RIDLE: begin
                    if (ar_hs) begin
                        raddr_q <= word_idx(araddr);
                        rcnt    <= RDLAT_LOAD;
                        if (RDLATENCY == 1) begin
                            rdata  <= mem[word_idx(araddr)];
                            rstate <= RDATA;
                        end else begin
                            rstate <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (rcnt == 4'd0) begin
                        rdata  <= mem[raddr_q];
                        rstate <= RDATA;
                    end else begin
                        rcnt <= rcnt - 4'd1;
                    end
                end
                RDATA:   if (rready) rstate <= RIDLE;
                default: rstate <= RIDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

Single-beat AXI4 memory responder that sits directly downstream of the VProc AXI bus functional model and terminates its write-address, write-data, write-response, read-address and read-data channels. It holds a word-addressed internal RAM, accepts write address and write data in either order or together, and returns read data after a programmable latency. It is the default memory target for processor test benches and exercises every acknowledge ordering the master supports.

## Interface
- ADDRWIDTH, 32, byte address width of awaddr/araddr
- DATAWIDTH, 32, data width; legal values are 32 or 64
- MEMDEPTHLOG2, 10, log2 of RAM depth in words
- RDLATENCY, 2, cycles from read-address acceptance to rvalid; legal range 1..15
- clk  input  1  clock; all logic on rising edge
- nreset  input  1  asynchronous, active-low reset
- awaddr  input  ADDRWIDTH  write byte address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- awprot  input  3  accepted and ignored
- wdata  input  DATAWIDTH  write data
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- wlast  input  1  accepted and ignored (single-beat only)
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  ADDRWIDTH  read byte address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- arprot  input  3  accepted and ignored
- rdata  output  DATAWIDTH  read data
- rvalid  output  1  read data valid
- rready  input  1  read data ready

## Operation
- Word index = addr[MEMDEPTHLOG2+A-1:A], where A=2 for 32-bit data and A=3 for 64-bit data. Address bits above the index are ignored, so addresses alias. Low A bits are ignored.
- Write FSM has four states: WIDLE, WADDR (address held), WDATA (data held), WRESP.
  - awready = 1 in WIDLE and WDATA.
  - wready = 1 in WIDLE and WADDR.
  - Both readies are 0 in WRESP.
  - WIDLE: on aw handshake and w handshake in the same cycle, commit the write and go to WRESP. On aw only, latch the address and go to WADDR. On w only, latch the data and go to WDATA.
  - WADDR: on w handshake, commit with the latched address and go to WRESP.
  - WDATA: on aw handshake, commit with the latched data and go to WRESP.
  - WRESP: bvalid = 1. When bvalid & bready, go to WIDLE.
- Commit means the RAM word is written on the same rising edge as the completing handshake.
- Read FSM has three states: RIDLE, RWAIT, RDATA.
  - arready = 1 only in RIDLE.
  - On ar handshake, latch the index and load the counter with RDLATENCY-1. Go to RDATA if RDLATENCY=1, otherwise go to RWAIT.
  - RWAIT: decrement the counter each cycle. Go to RDATA on the edge where the counter is 0.
  - The RAM is sampled into the rdata register on the edge entering RDATA.
  - RDATA: rvalid = 1. rdata is held stable until rvalid & rready, then go to RIDLE.
- The read and write FSMs are independent and may be active concurrently.
- Same-word collision: if a write commit and the rdata capture fall on the same edge, rdata returns the old (pre-write) word. A write committed on any earlier edge is visible.
- RAM content is zero at time 0 and is not affected by reset.

## Timing
- Reset values (asserted asynchronously):
  - Both FSMs go to their idle states.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, rdata=0.
  - Latched address, data and counter are 0.
- Reset mid-transaction discards every pending or held channel. No bvalid or rvalid is produced for that transaction, and no RAM write occurs unless the commit edge preceded reset assertion.
- Readies are combinational from FSM state only, with no combinational path from any valid. bvalid, rvalid and rdata are registered.
- Write latency: a commit at edge T gives bvalid=1 in the cycle after T. The minimum write cycle is 2 clocks when bready is held high.
- Read latency: an ar handshake at edge T gives rvalid=1 after edge T+RDLATENCY. The minimum read cycle is RDLATENCY+1 clocks when rready is held high.
- Back-to-back transactions: a new aw, w or ar is accepted on the cycle after the response handshake, never in the same cycle.
- The response outputs hold value under backpressure (bready or rready low) indefinitely.

## Test plan
- Simultaneous aw/w (addr 0x10, data 0xDEADBEEF, bready=1) -> awready=wready=1 at handshake; bvalid for exactly 1 cycle, one clock later; word 4 = 0xDEADBEEF.
- Address-first (aw 0x20, w 0x12345678 three cycles later) then data-first (w 0xCAFEF00D, aw 0x24 two cycles later) -> each commits at the completing handshake; readback gives 0x12345678 and 0xCAFEF00D.
- Read of 0x10 with RDLATENCY=2 and 5 -> rvalid exactly 2 or 5 cycles after the ar handshake; rdata=0xDEADBEEF; arready low until rvalid & rready.
- Backpressure: hold bready=0 and rready=0 for 4 cycles -> bvalid and rvalid/rdata stay stable; awready, wready and arready stay 0.
- Collision: a write of 0x55AA55AA to word 8 commits on the rdata-capture edge of a read of word 8 -> rdata returns the old value; the next read returns 0x55AA55AA. Also cover aliasing: write 0x1004 with MEMDEPTHLOG2=10 is read back at 0x0004.
- Drive nreset low while in WADDR and RWAIT, release 3 cycles later -> outputs at reset values, no bvalid or rvalid produced, RAM unchanged; a subsequent normal write/read completes correctly.
